d_ff_n: RTL and testbench

Parameterised N-bit enabled register with asynchronous active-low reset. Generic storage primitive for the VGA controller datapath (counters, pixel/coordinate latches): captures a data word on a clock edge when enabled and holds it otherwise. Purely sequential; no arithmetic.

---
 rtl/d_ff_n_pkg.sv | 10 +
 rtl/d_ff_n_bit.sv | 45 ++++
 rtl/d_ff_n.sv | 55 +++++
 tb/tb_d_ff_n.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/d_ff_n_pkg.sv
// Shared constants and types for the d_ff_n storage primitive.
//   D_FF_N_DEFAULT_W : default word width (VGA coordinate width)
//   d_ff_n_word_t    : default-width data word
package d_ff_n_pkg;

    localparam int unsigned D_FF_N_DEFAULT_W = 11;

    typedef logic [D_FF_N_DEFAULT_W-1:0] d_ff_n_word_t;

endpackage : d_ff_n_pkg

// File: rtl/d_ff_n_bit.sv
// Single-bit enabled flop with asynchronous active-low reset.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset, loads RST_VAL_BIT
//   en  : capture enable, active-high
//   d   : data bit
//   q   : registered data bit
module d_ff_n_bit
    import d_ff_n_pkg::*;
#(
    parameter logic RST_VAL_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    logic q_q;
    logic q_d;

    // Hold unless enabled; an X on en propagates to q in simulation.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end else if (!en) begin
            q_d = q_q;
        end else begin
            q_d = 1'bx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= RST_VAL_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : d_ff_n_bit

// File: rtl/d_ff_n.sv
// Parameterised N-bit enabled register with asynchronous active-low reset.
// Built from N single-bit flops; each gets its own bit of RST_VAL.
// Parameters:
//   N       : data width (>= 1)
//   RST_VAL : value loaded into q while rst is low
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   en  : capture enable, active-high
//   d   : N-bit data word
//   q   : N-bit registered data
// Optional macro D_FF_N_ASSERT_EN compiles in behavioural assertions;
// it does not change the logic.
module d_ff_n
    import d_ff_n_pkg::*;
#(
    parameter int unsigned N       = D_FF_N_DEFAULT_W,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    for (genvar i = 0; i < int'(N); i++) begin : g_bit
        d_ff_n_bit #(
            .RST_VAL_BIT (RST_VAL[i])
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (d[i]),
            .q   (q[i])
        );
    end

`ifdef D_FF_N_ASSERT_EN
    // Reset holds q at its reset value.
    a_rst_val : assert property (@(posedge clk) !rst |-> (q == RST_VAL))
        else $error("%m: q differs from RST_VAL while rst is low");

    // Disabled edge leaves q unchanged.
    a_hold : assert property (@(posedge clk)
        (rst && $past(rst) && !$past(en)) |-> $stable(q))
        else $error("%m: q changed on an edge with en low");

    // Enabled edge captures the previous cycle's d.
    a_capture : assert property (@(posedge clk)
        (rst && $past(rst) && $past(en)) |-> (q == $past(d)))
        else $error("%m: q does not match captured d");
`endif

endmodule : d_ff_n

// File: tb/tb_d_ff_n.sv
// Directed testbench for d_ff_n: one instance with default RST_VAL (0)
// and one with RST_VAL=5, sharing all inputs.
module tb_d_ff_n;

    localparam int unsigned W = 11;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] d;
    logic [W-1:0] q0;
    logic [W-1:0] q5;

    int errors;
    int checks;

    d_ff_n #(.N(W)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (d),
        .q   (q0)
    );

    d_ff_n #(.N(W), .RST_VAL(11'd5)) u_dut5 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (d),
        .q   (q5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        d   = 11'd250;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (q0 !== 11'd0) begin
            errors++;
            $display("FAIL reset_pre_edge q0: got %0d expected 0", q0);
        end
        checks++;
        if (q5 !== 11'd5) begin
            errors++;
            $display("FAIL reset_pre_edge q5: got %0d expected 5", q5);
        end
        edge_sample();
        checks++;
        if (q0 !== 11'd0) begin
            errors++;
            $display("FAIL reset_after_edge q0: got %0d expected 0", q0);
        end
    endtask

    task automatic test_en_low();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        d   = 11'd250;
        edge_sample();
        checks++;
        if (q0 !== 11'd0) begin
            errors++;
            $display("FAIL en_low_after_release q0: got %0d expected 0", q0);
        end
        checks++;
        if (q5 !== 11'd5) begin
            errors++;
            $display("FAIL en_low_after_release q5: got %0d expected 5", q5);
        end
    endtask

    task automatic test_capture();
        @(negedge clk);
        en = 1'b1;
        d  = 11'd250;
        #1;
        // No combinational path: q must not follow d/en before the edge.
        checks++;
        if (q0 !== 11'd0) begin
            errors++;
            $display("FAIL no_comb_path q0: got %0d expected 0", q0);
        end
        edge_sample();
        checks++;
        if (q0 !== 11'd250) begin
            errors++;
            $display("FAIL capture q0: got %0d expected 250", q0);
        end
        checks++;
        if (q5 !== 11'd250) begin
            errors++;
            $display("FAIL capture q5: got %0d expected 250", q5);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        en = 1'b0;
        d  = 11'd100;
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            checks++;
            if (q0 !== 11'd250) begin
                errors++;
                $display("FAIL hold[%0d] q0: got %0d expected 250", i, q0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] vec [3];
        int           reps [3];
        vec[0] = 11'd100;  reps[0] = 2;
        vec[1] = 11'd300;  reps[1] = 2;
        vec[2] = 11'd2047; reps[2] = 1;
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            en = 1'b1;
            d  = vec[v];
            for (int r = 0; r < reps[v]; r++) begin
                edge_sample();
                checks++;
                if (q0 !== vec[v]) begin
                    errors++;
                    $display("FAIL b2b[%0d.%0d] q0: got %0d expected %0d", v, r, q0, vec[v]);
                end
                checks++;
                if (q5 !== vec[v]) begin
                    errors++;
                    $display("FAIL b2b[%0d.%0d] q5: got %0d expected %0d", v, r, q5, vec[v]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        en = 1'b1;
        d  = 11'd300;
        edge_sample();
        checks++;
        if (q0 !== 11'd300) begin
            errors++;
            $display("FAIL async_setup q0: got %0d expected 300", q0);
        end
        // Drop reset between edges; next posedge is 3 units away.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #0.5;
        checks++;
        if (q0 !== 11'd0) begin
            errors++;
            $display("FAIL async_mid q0: got %0d expected 0", q0);
        end
        checks++;
        if (q5 !== 11'd5) begin
            errors++;
            $display("FAIL async_mid q5: got %0d expected 5", q5);
        end
        // Reset wins over an enabled edge.
        edge_sample();
        checks++;
        if (q0 !== 11'd0) begin
            errors++;
            $display("FAIL reset_wins q0: got %0d expected 0", q0);
        end
        checks++;
        if (q5 !== 11'd5) begin
            errors++;
            $display("FAIL reset_wins q5: got %0d expected 5", q5);
        end
        // Release; first capture on the next edge.
        @(negedge clk);
        rst = 1'b1;
        d   = 11'd7;
        #1;
        checks++;
        if (q5 !== 11'd5) begin
            errors++;
            $display("FAIL release_no_edge q5: got %0d expected 5", q5);
        end
        edge_sample();
        checks++;
        if (q0 !== 11'd7) begin
            errors++;
            $display("FAIL release_capture q0: got %0d expected 7", q0);
        end
        checks++;
        if (q5 !== 11'd7) begin
            errors++;
            $display("FAIL release_capture q5: got %0d expected 7", q5);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_en_low();
        test_capture();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_d_ff_n
